// File: rtl/dc_coefficient_decoder_pkg.sv
// +----------------------------------------------------------------------------+
// | dc_coefficient_decoder_pkg : shared FSM state type and sizing constants    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package dc_coefficient_decoder_pkg;

    localparam int MAX_CODE_LEN = 16;
    localparam int CAT_W        = 4;

    typedef enum logic [1:0] {
        ST_CODE = 2'd0,
        ST_MAG  = 2'd1,
        ST_OUT  = 2'd2
    } dc_state_e;

endpackage

`default_nettype wire

// File: rtl/dc_coefficient_decoder_if.sv
// +----------------------------------------------------------------------------+
// | dc_coefficient_decoder_if : bit stream, Huffman table and DC output bus    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface dc_coefficient_decoder_if #(
    parameter int COEF_W = 12
);
    import dc_coefficient_decoder_pkg::*;

    logic                     bit_in;
    logic                     bit_valid;
    logic                     bit_ready;
    logic [0:15]              bit_series;
    logic [4:0]               length;
    logic [CAT_W-1:0]         s_value;
    logic [CAT_W-1:0]         r_value;
    logic                     is_valid;
    logic                     pred_clear;
    logic signed [COEF_W-1:0] dc_value;
    logic                     dc_valid;
    logic                     dc_ready;
    logic                     code_error;

    modport master (
        output bit_in, bit_valid, s_value, r_value, is_valid, pred_clear, dc_ready,
        input  bit_ready, bit_series, length, dc_value, dc_valid, code_error
    );

    modport slave (
        input  bit_in, bit_valid, s_value, r_value, is_valid, pred_clear, dc_ready,
        output bit_ready, bit_series, length, dc_value, dc_valid, code_error
    );

endinterface

`default_nettype wire

// File: rtl/dc_coefficient_decoder_magnitude_extend.sv
// +----------------------------------------------------------------------------+
// | dc_magnitude_extend : turns r magnitude bits into a signed DC difference   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module dc_magnitude_extend
    import dc_coefficient_decoder_pkg::*;
#(
    parameter int COEF_W = 12
) (
    input  wire  [CAT_W-1:0]         r,
    input  wire  [15:0]              bits,
    output logic signed [COEF_W-1:0] diff
);

    localparam int EXT_W = (COEF_W > 16) ? COEF_W : 16;

    logic [EXT_W-1:0] w_bits;
    logic [EXT_W-1:0] w_mask;
    logic [EXT_W-1:0] w_ext;
    logic             w_first;

    // A leading 0 marks a negative value: subtract 2^r - 1 from the raw bits.
    always_comb begin
        w_bits  = EXT_W'(bits);
        w_mask  = (EXT_W'(1) << r) - EXT_W'(1);
        w_first = (r == '0) ? 1'b0 : bits[r - 4'd1];
        w_ext   = w_first ? w_bits : (w_bits - w_mask);
        diff    = (r == '0) ? '0 : w_ext[COEF_W-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/dc_coefficient_decoder.sv
// +----------------------------------------------------------------------------+
// | dc_coefficient_decoder : serial Huffman DC decoder (CODE/MAG/OUT FSM).     |
// | Optional macro DC_PREDICTION_EN adds the DC predictor.  Rev 1.0            |
// +----------------------------------------------------------------------------+
`default_nettype none

module dc_coefficient_decoder #(
    parameter int COEF_W       = 12,
    parameter int MAX_CODE_LEN = dc_coefficient_decoder_pkg::MAX_CODE_LEN
) (
    input wire                      clk,
    input wire                      rst_n,
    dc_coefficient_decoder_if.slave bus
);
    import dc_coefficient_decoder_pkg::*;

    localparam logic [4:0] MAX_LEN = 5'(MAX_CODE_LEN);

    dc_state_e                r_state;
    dc_state_e                w_next_state;
    logic [0:15]              r_series;
    logic [4:0]               r_length;
    logic [CAT_W-1:0]         r_cat;
    logic [CAT_W-1:0]         r_mag_cnt;
    logic [15:0]              r_mag_bits;
    logic [15:0]              w_mag_next;
    logic signed [COEF_W-1:0] r_dc_value;
    logic signed [COEF_W-1:0] w_diff;
    logic signed [COEF_W-1:0] w_base;
    logic                     r_code_error;
    logic                     w_ready;
    logic                     w_match;
    logic                     w_fail;
    logic                     w_last_mag;

    assign w_mag_next = {r_mag_bits[14:0], bus.bit_in};

    dc_magnitude_extend #(.COEF_W(COEF_W)) u_mag_extend (
        .r    (r_cat),
        .bits (w_mag_next),
        .diff (w_diff)
    );

`ifdef DC_PREDICTION_EN
    logic signed [COEF_W-1:0] r_pred;
    logic                     w_handshake;
    logic                     w_unused;

    assign w_handshake = (r_state == ST_OUT) && bus.dc_ready;
    assign w_unused    = ^bus.s_value;

    // A clear takes priority over the update from a same-cycle handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              r_pred <= '0;
        else if (bus.pred_clear) r_pred <= '0;
        else if (w_handshake)    r_pred <= r_dc_value;
    end

    assign w_base = r_pred;
`else
    logic w_unused;

    assign w_unused = ^{bus.s_value, bus.pred_clear};
    assign w_base   = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_CODE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_match      = 1'b0;
        w_fail       = 1'b0;
        w_last_mag   = 1'b0;
        case (r_state)
            ST_CODE: begin
                w_match = bus.is_valid && (r_length != 5'd0);
                w_fail  = !bus.is_valid && (r_length == MAX_LEN);
                w_ready = !w_match;
                if (w_match) w_next_state = (bus.r_value != '0) ? ST_MAG : ST_OUT;
            end
            ST_MAG: begin
                w_ready    = 1'b1;
                w_last_mag = bus.bit_valid && (r_mag_cnt == r_cat - 4'd1);
                if (w_last_mag) w_next_state = ST_OUT;
            end
            ST_OUT: begin
                if (bus.dc_ready) w_next_state = ST_CODE;
            end
            default: w_next_state = ST_CODE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_series     <= '0;
            r_length     <= '0;
            r_cat        <= '0;
            r_mag_cnt    <= '0;
            r_mag_bits   <= '0;
            r_dc_value   <= '0;
            r_code_error <= 1'b0;
        end else begin
            case (r_state)
                ST_CODE: begin
                    if (w_match) begin
                        r_cat      <= bus.r_value;
                        r_series   <= '0;
                        r_length   <= '0;
                        r_mag_cnt  <= '0;
                        r_mag_bits <= '0;
                        if (bus.r_value == '0) r_dc_value <= w_base;
                    end else if (w_fail) begin
                        r_code_error <= 1'b1;
                        r_series     <= '0;
                        r_length     <= '0;
                    end else if (bus.bit_valid) begin
                        r_series[r_length[3:0]] <= bus.bit_in;
                        r_length                <= r_length + 5'd1;
                    end
                end
                ST_MAG: begin
                    if (bus.bit_valid) begin
                        r_mag_bits <= w_mag_next;
                        r_mag_cnt  <= r_mag_cnt + 4'd1;
                        if (w_last_mag) r_dc_value <= w_base + w_diff;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bit_ready  = w_ready;
    assign bus.bit_series = r_series;
    assign bus.length     = r_length;
    assign bus.dc_value   = r_dc_value;
    assign bus.dc_valid   = (r_state == ST_OUT);
    assign bus.code_error = r_code_error;

endmodule

`default_nettype wire

// File: tb/tb_dc_coefficient_decoder.sv
// +----------------------------------------------------------------------------+
// | tb_dc_coefficient_decoder : directed bench with a small DC Huffman table.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dc_coefficient_decoder;
    import dc_coefficient_decoder_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    dc_coefficient_decoder_if #(.COEF_W(12)) bus ();

    dc_coefficient_decoder #(.COEF_W(12), .MAX_CODE_LEN(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Table: 00->r0, 010->r1, 011->r2, 100->r3, 1110->r11.
    always_comb begin
        bus.is_valid = 1'b0;
        bus.r_value  = 4'd0;
        bus.s_value  = 4'd0;
        case (bus.length)
            5'd2: if (bus.bit_series[0:1] == 2'b00) bus.is_valid = 1'b1;
            5'd3: begin
                case (bus.bit_series[0:2])
                    3'b010:  begin bus.is_valid = 1'b1; bus.r_value = 4'd1; end
                    3'b011:  begin bus.is_valid = 1'b1; bus.r_value = 4'd2; end
                    3'b100:  begin bus.is_valid = 1'b1; bus.r_value = 4'd3; end
                    default: ;
                endcase
            end
            5'd4: if (bus.bit_series[0:3] == 4'b1110) begin
                bus.is_valid = 1'b1;
                bus.r_value  = 4'd11;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        int n;
        n = 0;
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        while (bus.bit_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) chk("bit_ready_timeout", {31'd0, bus.bit_ready}, 32'd1);
        @(posedge clk); #1;
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] v, input int len);
        for (int i = len - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic wait_dc(input string tag, input logic [11:0] exp, input logic pc);
        int n;
        n = 0;
        while (bus.dc_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_valid"}, {31'd0, bus.dc_valid}, 32'd1);
        chk(tag, {20'd0, bus.dc_value}, {20'd0, exp});
        bus.dc_ready   = 1'b1;
        bus.pred_clear = pc;
        @(posedge clk); #1;
        bus.dc_ready   = 1'b0;
        bus.pred_clear = 1'b0;
        chk({tag, "_done"}, {31'd0, bus.dc_valid}, 32'd0);
    endtask

    initial begin
        bus.bit_in     = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.dc_ready   = 1'b0;
        bus.pred_clear = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_dc_valid", {31'd0, bus.dc_valid}, 32'd0);
        chk("rst_dc_value", {20'd0, bus.dc_value}, 32'd0);
        chk("rst_length", {27'd0, bus.length}, 32'd0);
        chk("rst_code_error", {31'd0, bus.code_error}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release_bit_ready", {31'd0, bus.bit_ready}, 32'd1);

        // Code 00, category 0: valid one cycle after the match cycle.
        send_bits(16'b00, 2);
        chk("c00_length", {27'd0, bus.length}, 32'd2);
        chk("c00_not_yet", {31'd0, bus.dc_valid}, 32'd0);
        @(posedge clk); #1;
        chk("c00_latency", {31'd0, bus.dc_valid}, 32'd1);
        chk("c00_length_clr", {27'd0, bus.length}, 32'd0);
        wait_dc("c00_value", 12'h000, 1'b0);

        // Code 100 (r=3), bits 110 -> +6
        send_bits(16'b100, 3);
        send_bits(16'b110, 3);
        chk("p6_latency", {31'd0, bus.dc_valid}, 32'd1);
        wait_dc("p6_value", 12'h006, 1'b0);

        // Code 011 (r=2), bits 01 -> -2; consumer stalls for 5 cycles
        send_bits(16'b011, 3);
        send_bits(16'b01, 2);
        bus.bit_in    = 1'b1;
        bus.bit_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
`ifdef DC_PREDICTION_EN
            chk("stall_value", {20'd0, bus.dc_value}, 32'h004);
`else
            chk("stall_value", {20'd0, bus.dc_value}, 32'hFFE);
`endif
            chk("stall_ready", {31'd0, bus.bit_ready}, 32'd0);
            chk("stall_length", {27'd0, bus.length}, 32'd0);
        end
        bus.bit_valid = 1'b0;
`ifdef DC_PREDICTION_EN
        wait_dc("m2_value", 12'h004, 1'b0);
        wait_dc_pending: ;
`else
        wait_dc("m2_value", 12'hFFE, 1'b0);
`endif

        // Zero-diff block with pred_clear on its handshake
        send_bits(16'b00, 2);
`ifdef DC_PREDICTION_EN
        wait_dc("clr_value", 12'h004, 1'b1);
`else
        wait_dc("clr_value", 12'h000, 1'b1);
`endif
        // Code 1110 (r=11), eleven ones -> +2047, equal to its own diff
        send_bits(16'b1110, 4);
        send_bits(16'h07FF, 11);
        wait_dc("max_value", 12'h7FF, 1'b0);
        // Code 010 (r=1), bit 1 -> +1, wraps with prediction
        send_bits(16'b010, 3);
        send_bits(16'b1, 1);
`ifdef DC_PREDICTION_EN
        wait_dc("wrap_value", 12'h800, 1'b0);
`else
        wait_dc("wrap_value", 12'h001, 1'b0);
`endif

        // Sixteen ones never match: error, flush, resume
        send_bits(16'hFFFF, 16);
        chk("err_full_length", {27'd0, bus.length}, 32'd16);
        @(posedge clk); #1;
        chk("err_flag", {31'd0, bus.code_error}, 32'd1);
        chk("err_length", {27'd0, bus.length}, 32'd0);
        send_bits(16'b00, 2);
`ifdef DC_PREDICTION_EN
        wait_dc("resume_value", 12'h800, 1'b0);
`else
        wait_dc("resume_value", 12'h000, 1'b0);
`endif
        chk("err_sticky", {31'd0, bus.code_error}, 32'd1);

        // Asynchronous reset in the middle of a magnitude field
        send_bits(16'b100, 3);
        send_bit(1'b1);
        chk("mid_state_mag", 32'(dut.r_state), 32'(ST_MAG));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dc_valid", {31'd0, bus.dc_valid}, 32'd0);
        chk("arst_dc_value", {20'd0, bus.dc_value}, 32'd0);
        chk("arst_code_error", {31'd0, bus.code_error}, 32'd0);
        chk("arst_length", {27'd0, bus.length}, 32'd0);
        chk("arst_series", {16'd0, bus.bit_series}, 32'd0);
        chk("arst_state", 32'(dut.r_state), 32'(ST_CODE));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_bit_ready", {31'd0, bus.bit_ready}, 32'd1);
        // Code 011 (r=2), bits 10 -> +2 from a cleared predictor
        send_bits(16'b011, 3);
        send_bits(16'b10, 2);
        wait_dc("post_rst_value", 12'h002, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
